// File: rtl/inv_mixcolumns_iter.sv
// AES-128 InvMixColumns engine with a valid/ready handshake on both sides.
// Default build: one column datapath, four BUSY cycles (one per column).
// With INV_MIXCOL_SINGLE_CYCLE_EN defined: four column datapaths, one BUSY cycle.
// The interface, reset values and handshake behaviour are the same in both builds.
module inv_mixcolumns_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q;
  logic [127:0] data_q;
  logic [127:0] out_q;
  logic         in_ready_q;
  logic         out_valid_q;

  // GF(2^8) doubling modulo 0x11B; the result stays 8 bits wide.
  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k using the x2/x4/x8 chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    gmul = (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // One column: b_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3).
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    inv_col[31:24] = gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9);
    inv_col[23:16] = gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD) ^ gmul(a0, 4'h9);
    inv_col[15:8]  = gmul(a2, 4'hE) ^ gmul(a3, 4'hB) ^ gmul(a0, 4'hD) ^ gmul(a1, 4'h9);
    inv_col[7:0]   = gmul(a3, 4'hE) ^ gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9);
  endfunction

`ifdef INV_MIXCOL_SINGLE_CYCLE_EN
  logic [127:0] res;

  // Four independent column datapaths over the whole captured state.
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign res[32*c +: 32] = inv_col(data_q[32*c +: 32]);
  end
`else
  logic [1:0]  cnt_q;
  logic [31:0] col_in;
  logic [31:0] col_out;

  // Select the column addressed by the counter; column 0 sits in the top word.
  always_comb begin
    col_in = data_q[127:96];
    case (cnt_q)
      2'd0:    col_in = data_q[127:96];
      2'd1:    col_in = data_q[95:64];
      2'd2:    col_in = data_q[63:32];
      default: col_in = data_q[31:0];
    endcase
  end

  assign col_out = inv_col(col_in);
`endif

  // Handshake FSM; capture, column writes and output flags are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= 128'h0;
      out_q       <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifndef INV_MIXCOL_SINGLE_CYCLE_EN
      cnt_q       <= 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= state_in;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
`ifndef INV_MIXCOL_SINGLE_CYCLE_EN
            cnt_q      <= 2'd0;
`endif
          end
        end
        BUSY: begin
`ifdef INV_MIXCOL_SINGLE_CYCLE_EN
          out_q       <= res;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
`else
          case (cnt_q)
            2'd0:    out_q[127:96] <= col_out;
            2'd1:    out_q[95:64]  <= col_out;
            2'd2:    out_q[63:32]  <= col_out;
            default: out_q[31:0]   <= col_out;
          endcase
          cnt_q <= cnt_q + 2'd1;
          // Last column lands on the same edge that enters DONE.
          if (cnt_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Scoreboard bench for inv_mixcolumns_iter: stimulus pushes expected results,
// a monitor pops and compares on every out_valid/out_ready transfer.
module tb_inv_mixcolumns_iter;

`ifdef INV_MIXCOL_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] state_out;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];
  bit rnd_rdy = 1'b0;

  inv_mixcolumns_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Forward MixColumns reference, used to build round-trip vectors.
  function automatic logic [7:0] x2(input logic [7:0] a);
    x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      fwd_mix[127-32*c -: 8] = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
      fwd_mix[119-32*c -: 8] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
      fwd_mix[111-32*c -: 8] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
      fwd_mix[103-32*c -: 8] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
    end
  endfunction

  // Monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", state_out, 128'hx);
      else chk("result", state_out, exp_q.pop_front());
    end
  end

  // Random consumer back-pressure during the round-trip phase.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic accept(input logic [127:0] s, input logic [127:0] e, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait_ready", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    state_in = s;
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_queue_empty", 128'(exp_q.size()), 128'h0);
  endtask

  localparam logic [127:0] V1I = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1O = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2I = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [127:0] V2O = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;
  // Same columns in different positions; uniform columns map to themselves.
  localparam logic [127:0] V3I = 128'hc6c6c6c6_d5d5d7d6_9fdc589d_4d7ebdf8;
  localparam logic [127:0] V3O = 128'hc6c6c6c6_d4d4d4d5_f20a225c_2d26314c;

  initial begin
    logic [127:0] x;
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_state_out", state_out, 128'h0);

    // Vector 1 with latency check
    accept(V1I, V1O, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", {127'h0, out_valid}, (k == LAT) ? 128'h1 : 128'h0);
      if (k < LAT) chk("busy_in_ready", {127'h0, in_ready}, 128'h0);
    end
    wait_idle();

    // Vectors 2 and 3 back to back
    accept(V2I, V2O, 1'b1);
    accept(V3I, V3O, 1'b1);
    wait_idle();

    // Stall in DONE for 10 cycles
    out_ready = 1'b0;
    accept(V2I, V2O, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 10; k++) begin
      chk("stall_out_valid", {127'h0, out_valid}, 128'h1);
      chk("stall_state_out", state_out, V2O);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {127'h0, in_ready}, 128'h1);
    chk("release_out_valid", {127'h0, out_valid}, 128'h0);
    wait_idle();

    // in_valid held with changing data: only the first value is processed
    in_valid = 1'b1;
    state_in = V3I;
    @(posedge clk);
    exp_q.push_back(V3O);
    #1;
    n = 0;
    while (!out_valid && n < 20) begin
      chk("hold_in_ready", {127'h0, in_ready}, 128'h0);
      state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("hold_out_valid_seen", {127'h0, out_valid}, 128'h1);
    wait_idle();

    // Reset in the second BUSY cycle discards the block
    accept(V1I, V1O, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("midrst_state_out", state_out, 128'h0);
    chk("midrst_in_ready", {127'h0, in_ready}, 128'h1);
    accept(V1I, V1O, 1'b1);
    wait_idle();

    // Round trip: feed MixColumns(x), expect x back, random back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      accept(fwd_mix(x), x, 1'b1);
    end
    rnd_rdy = 1'b0;
    #1 out_ready = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
